display_count_ctrl: RTL and testbench

Controller that sequences the two-digit BCD count shown on the dual 7-segment display. It arbitrates between manual increment/decrement requests and an internal auto-count timer, and owns the 00–99 wrap rules. It flags wraps with a timed blank/flash phase. It sits between the debounced-switch edge detectors and the two seven_segment decoder instances.

---
 rtl/display_count_ctrl.sv | 161 ++++++++++++++++
 tb/tb_display_count_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/display_count_ctrl.sv
// Two-digit BCD count sequencer: manual inc/dec, auto up/down counting,
// and a timed blank/flash phase whenever the count wraps.
module display_count_ctrl #(
  parameter int unsigned TICK_CYCLES  = 25000000,
  parameter int unsigned BLINK_CYCLES = 6250000,
  parameter int unsigned DIGIT_MAX    = 9
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Inc_Pulse,
  input  logic       i_Dec_Pulse,
  input  logic       i_Mode_Pulse,
  output logic [3:0] o_Tens,
  output logic [3:0] o_Ones,
  output logic       o_Blank,
  output logic       o_Wrap,
  output logic [1:0] o_State
);

  localparam int unsigned TW          = $clog2(TICK_CYCLES);
  localparam int unsigned BLINK_TOTAL = 4 * BLINK_CYCLES;
  localparam int unsigned BW          = $clog2(BLINK_TOTAL);

  localparam logic [3:0]    DMAX       = 4'(DIGIT_MAX);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TOTAL - 1);
  localparam logic [BW-1:0] BLINK_1    = BW'(BLINK_CYCLES);
  localparam logic [BW-1:0] BLINK_2    = BW'(2 * BLINK_CYCLES);
  localparam logic [BW-1:0] BLINK_3    = BW'(3 * BLINK_CYCLES);

  typedef enum logic [1:0] {
    MANUAL     = 2'd0,
    AUTO_UP    = 2'd1,
    AUTO_DOWN  = 2'd2,
    WRAP_FLASH = 2'd3
  } state_e;

  state_e        state_q, state_d;
  state_e        saved_q, saved_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic          blank_q, blank_d;
  logic          wrap_q, wrap_d;
  logic          step_up, step_dn;

  // State register and registered outputs
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= MANUAL;
      saved_q <= MANUAL;
      tick_q  <= '0;
      blink_q <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      blank_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      tick_q  <= tick_d;
      blink_q <= blink_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      blank_q <= blank_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next-state, step selection, digit arithmetic and wrap handling
  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    tick_d  = tick_q;
    blink_d = blink_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    wrap_d  = 1'b0;
    blank_d = 1'b0;
    step_up = 1'b0;
    step_dn = 1'b0;

    case (state_q)
      MANUAL: begin
        if (i_Mode_Pulse) begin
          state_d = AUTO_UP;
          tick_d  = '0;
        end else if (i_Inc_Pulse && !i_Dec_Pulse) begin
          step_up = 1'b1;
        end else if (i_Dec_Pulse && !i_Inc_Pulse) begin
          step_dn = 1'b1;
        end
      end
      AUTO_UP, AUTO_DOWN: begin
        if (i_Mode_Pulse) begin
          state_d = (state_q == AUTO_UP) ? AUTO_DOWN : MANUAL;
          tick_d  = '0;
        end else if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          step_up = (state_q == AUTO_UP);
          step_dn = (state_q == AUTO_DOWN);
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      WRAP_FLASH: begin
        if (blink_q == BLINK_LAST) begin
          state_d = saved_q;
          tick_d  = '0;
          blink_d = '0;
        end else begin
          blink_d = blink_q + BW'(1);
        end
      end
      default: state_d = MANUAL;
    endcase

    if (step_up) begin
      if (tens_q == DMAX && ones_q == DMAX) begin
        tens_d = '0;
        ones_d = '0;
        wrap_d = 1'b1;
      end else if (ones_q < DMAX) begin
        ones_d = ones_q + 4'd1;
      end else begin
        ones_d = '0;
        tens_d = tens_q + 4'd1;
      end
    end else if (step_dn) begin
      if (tens_q == 4'd0 && ones_q == 4'd0) begin
        tens_d = DMAX;
        ones_d = DMAX;
        wrap_d = 1'b1;
      end else if (ones_q > 4'd0) begin
        ones_d = ones_q - 4'd1;
      end else begin
        ones_d = DMAX;
        tens_d = tens_q - 4'd1;
      end
    end

    // A wrap parks the current mode and starts the flash from blink count 0
    if (wrap_d) begin
      saved_d = state_q;
      state_d = WRAP_FLASH;
      blink_d = '0;
      tick_d  = '0;
    end

    blank_d = (state_d == WRAP_FLASH) &&
              ((blink_d < BLINK_1) || ((blink_d >= BLINK_2) && (blink_d < BLINK_3)));
  end

  assign o_Tens  = tens_q;
  assign o_Ones  = ones_q;
  assign o_Blank = blank_q;
  assign o_Wrap  = wrap_q;
  assign o_State = state_q;

endmodule

// File: tb/tb_display_count_ctrl.sv
// Directed bench for display_count_ctrl with TICK_CYCLES=4, BLINK_CYCLES=3.
module tb_display_count_ctrl;

  logic       clk;
  logic       rst_n;
  logic       inc, dec, mode;
  logic [3:0] tens, ones;
  logic       blank, wrap;
  logic [1:0] state;

  int n_pass  = 0;
  int n_total = 0;

  display_count_ctrl #(
    .TICK_CYCLES (4),
    .BLINK_CYCLES(3),
    .DIGIT_MAX   (9)
  ) dut (
    .i_Clk       (clk),
    .i_Rst_L     (rst_n),
    .i_Inc_Pulse (inc),
    .i_Dec_Pulse (dec),
    .i_Mode_Pulse(mode),
    .o_Tens      (tens),
    .o_Ones      (ones),
    .o_Blank     (blank),
    .o_Wrap      (wrap),
    .o_State     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [7:0] bcd(input int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  task automatic chk_cnt(input string tag, input int v);
    chk(tag, 32'({tens, ones}), 32'(bcd(v)));
  endtask

  // Drive one cycle of requests from a negedge; return at the next negedge
  task automatic step_cyc(input logic i, input logic d, input logic m);
    inc = i; dec = d; mode = m;
    @(negedge clk);
    inc = 1'b0; dec = 1'b0; mode = 1'b0;
  endtask

  // Entered on the first flash cycle; stray inc and mode are injected and must be ignored
  task automatic chk_flash(input int cnt, input logic [1:0] ret_state);
    for (int i = 0; i < 12; i++) begin
      chk("flash_blank", 32'(blank), 32'((i < 3) || (i >= 6 && i < 9)));
      chk("flash_state", 32'(state), 32'd3);
      chk("flash_wrap", 32'(wrap), 32'(i == 0));
      chk_cnt("flash_hold", cnt);
      step_cyc(i == 4, 1'b0, i == 7);
    end
    chk("flash_ret_state", 32'(state), 32'(ret_state));
    chk("flash_ret_blank", 32'(blank), 32'd0);
    chk_cnt("flash_ret_cnt", cnt);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    inc = 1'b0; dec = 1'b0; mode = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tens", 32'(tens), 32'd0);
    chk("rst_ones", 32'(ones), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_blank", 32'(blank), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Manual increments 00 -> 12
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      chk_cnt("pre_inc", cnt);
      step_cyc(1'b1, 1'b0, 1'b0);
      cnt++;
      chk_cnt("inc", cnt);
    end

    // Ones/tens borrow and carry around 09/10, simultaneous inc+dec
    for (int i = 0; i < 3; i++) begin
      step_cyc(1'b0, 1'b1, 1'b0);
      cnt--;
      chk_cnt("dec", cnt);
    end
    step_cyc(1'b1, 1'b0, 1'b0); chk_cnt("carry_10", 10);
    step_cyc(1'b0, 1'b1, 1'b0); chk_cnt("borrow_09", 9);
    step_cyc(1'b1, 1'b1, 1'b0); chk_cnt("inc_dec_hold", 9);
    chk("manual_wrap_low", 32'(wrap), 32'd0);

    // Down to 00, then wrap to 99 with flash
    cnt = 9;
    for (int i = 0; i < 9; i++) begin
      step_cyc(1'b0, 1'b1, 1'b0);
      cnt--;
      chk_cnt("dec_to_0", cnt);
    end
    step_cyc(1'b0, 1'b1, 1'b0);
    chk_cnt("wrap_dn_99", 99);
    chk_flash(99, 2'd0);

    // Up from 99 wraps to 00
    step_cyc(1'b1, 1'b0, 1'b0);
    chk_cnt("wrap_up_00", 0);
    chk_flash(0, 2'd0);

    // AUTO_UP steps every 4 cycles, inc ignored
    step_cyc(1'b0, 1'b0, 1'b1);
    for (int k = 0; k <= 8; k++) begin
      chk("auto_up_state", 32'(state), 32'd1);
      chk_cnt("auto_up_cnt", k / 4);
      if (k < 8) step_cyc(k == 1, 1'b0, 1'b0);
    end
    step_cyc(1'b0, 1'b0, 1'b1);
    for (int k = 0; k <= 7; k++) begin
      chk("auto_dn_state", 32'(state), 32'd2);
      chk_cnt("auto_dn_cnt", (k < 4) ? 2 : 1);
      if (k < 7) step_cyc(1'b0, k == 2, 1'b0);
    end
    // Mode+inc on a tick cycle: mode wins, no step
    step_cyc(1'b1, 1'b0, 1'b1);
    chk("mode_inc_state", 32'(state), 32'd0);
    chk_cnt("mode_inc_cnt", 1);
    step_cyc(1'b0, 1'b0, 1'b0);
    chk_cnt("mode_inc_cnt2", 1);

    // Reach 98 in MANUAL
    step_cyc(1'b0, 1'b1, 1'b0); chk_cnt("to_00", 0);
    step_cyc(1'b0, 1'b1, 1'b0); chk_cnt("to_99", 99);
    chk_flash(99, 2'd0);
    step_cyc(1'b0, 1'b1, 1'b0); chk_cnt("to_98", 98);

    // AUTO_UP wrap returns to AUTO_UP with tick restarted
    step_cyc(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      chk_cnt("auto_98_99", (k < 4) ? 98 : 99);
      step_cyc(1'b0, 1'b0, 1'b0);
    end
    chk("auto_wrap", 32'(wrap), 32'd1);
    chk_cnt("auto_wrap_00", 0);
    chk_flash(0, 2'd1);
    for (int k = 0; k <= 4; k++) begin
      chk_cnt("tick_restart", (k < 4) ? 0 : 1);
      if (k < 4) step_cyc(1'b0, 1'b0, 1'b0);
    end

    // AUTO_DOWN to a wrap, then reset mid-flash
    step_cyc(1'b0, 1'b0, 1'b1);
    chk("auto_dn2_state", 32'(state), 32'd2);
    repeat (8) @(negedge clk);
    chk("dn_wrap", 32'(wrap), 32'd1);
    chk("dn_wrap_state", 32'(state), 32'd3);
    chk_cnt("dn_wrap_99", 99);
    @(negedge clk);
    chk("mid_flash_blank", 32'(blank), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_tens", 32'(tens), 32'd0);
    chk("async_rst_ones", 32'(ones), 32'd0);
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_blank", 32'(blank), 32'd0);
    chk("async_rst_wrap", 32'(wrap), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step_cyc(1'b1, 1'b0, 1'b0);
    chk_cnt("post_rst_inc", 1);
    chk("post_rst_state", 32'(state), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
